// File: rtl/ssd_best_match_pkg.sv
// Shared widths, FSM encoding and a constant-foldable clog2 for the SSD best-match block.
package ssd_best_match_pkg;

  localparam int PIX_W = 8;
  localparam int SQR_W = 16;
  localparam int SUM_W = 18;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssd_best_match_sum4_reg.sv
// Stage 1: registered sum of the four squared-difference lanes; flush drops the beat.
module ssd_best_match_sum4_reg
  import ssd_best_match_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [SQR_W-1:0] z0_i,
  input  logic [SQR_W-1:0] z1_i,
  input  logic [SQR_W-1:0] z2_i,
  input  logic [SQR_W-1:0] z3_i,
  output logic [SUM_W-1:0] s1_sum_o,
  output logic             s1_vld_o
);

  logic [SUM_W-1:0] sum_d, sum_q;
  logic             vld_d, vld_q;

  always_comb begin
    sum_d = SUM_W'(z0_i) + SUM_W'(z1_i) + SUM_W'(z2_i) + SUM_W'(z3_i);
    vld_d = vld_i & ~flush_i;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sum_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      vld_q <= vld_d;
    end
  end

  assign s1_sum_o = sum_q;
  assign s1_vld_o = vld_q;

endmodule

// File: rtl/ssd_best_match.sv
// Accumulates BEATS beats per candidate into an SSD and tracks the minimum over CANDS candidates.
module ssd_best_match
  import ssd_best_match_pkg::*;
#(
  parameter  int BEATS = 16,
  parameter  int CANDS = 16,
  parameter  int IDX_W = 4,
  localparam int ACC_W = SUM_W + clog2(BEATS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             sqr_valid,
  input  logic [SQR_W-1:0] z0,
  input  logic [SQR_W-1:0] z1,
  input  logic [SQR_W-1:0] z2,
  input  logic [SQR_W-1:0] z3,
  output logic             busy,
  output logic             ssd_valid,
  output logic [ACC_W-1:0] ssd_out,
  output logic [IDX_W-1:0] cand_idx,
  output logic             done,
  output logic [ACC_W-1:0] best_ssd,
  output logic [IDX_W-1:0] best_idx
);

  localparam int BEAT_W = clog2(BEATS);
  localparam int CNT_W  = clog2(CANDS + 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  cand_cnt_q, cand_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  ssd_out_q, ssd_out_d;
  logic [IDX_W-1:0]  cand_idx_q, cand_idx_d;
  logic              ssd_valid_q, ssd_valid_d;
  logic              done_q, done_d;
  logic [ACC_W-1:0]  best_ssd_q, best_ssd_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [SUM_W-1:0]  s1_sum;
  logic              s1_vld;
  logic              stage2_fire;

  ssd_best_match_sum4_reg u_sum4 (
    .clk      (clk),
    .nrst     (nrst),
    .flush_i  (start),
    .vld_i    (sqr_valid & (state_q == RUN)),
    .z0_i     (z0),
    .z1_i     (z1),
    .z2_i     (z2),
    .z3_i     (z3),
    .s1_sum_o (s1_sum),
    .s1_vld_o (s1_vld)
  );

  // Beats reaching stage 2 after the last candidate (cand_cnt == CANDS) are dropped.
  assign stage2_fire = s1_vld && (state_q == RUN) && !start && (cand_cnt_q < CNT_W'(CANDS));

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    cand_cnt_d  = cand_cnt_q;
    acc_d       = acc_q;
    ssd_out_d   = ssd_out_q;
    cand_idx_d  = cand_idx_q;
    ssd_valid_d = 1'b0;
    done_d      = 1'b0;
    best_ssd_d  = best_ssd_q;
    best_idx_d  = best_idx_q;

    if (start) begin
      beat_cnt_d = '0;
      cand_cnt_d = '0;
      acc_d      = '0;
    end else if (stage2_fire) begin
      if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
        ssd_out_d   = acc_q + ACC_W'(s1_sum);
        cand_idx_d  = IDX_W'(cand_cnt_q);
        ssd_valid_d = 1'b1;
        acc_d       = '0;
        beat_cnt_d  = '0;
        cand_cnt_d  = cand_cnt_q + 1'b1;
      end else begin
        acc_d      = acc_q + ACC_W'(s1_sum);
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end

    // Strict less-than keeps the earliest index on ties.
    if (ssd_valid_q) begin
      if ((cand_idx_q == '0) || (ssd_out_q < best_ssd_q)) begin
        best_ssd_d = ssd_out_q;
        best_idx_d = cand_idx_q;
      end
      done_d = (cand_idx_q == IDX_W'(CANDS - 1));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!start && done_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      cand_cnt_q  <= '0;
      acc_q       <= '0;
      ssd_out_q   <= '0;
      cand_idx_q  <= '0;
      ssd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      best_ssd_q  <= '0;
      best_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cand_cnt_q  <= cand_cnt_d;
      acc_q       <= acc_d;
      ssd_out_q   <= ssd_out_d;
      cand_idx_q  <= cand_idx_d;
      ssd_valid_q <= ssd_valid_d;
      done_q      <= done_d;
      best_ssd_q  <= best_ssd_d;
      best_idx_q  <= best_idx_d;
    end
  end

  assign ssd_valid = ssd_valid_q;
  assign ssd_out   = ssd_out_q;
  assign cand_idx  = cand_idx_q;
  assign done      = done_q;
  assign best_ssd  = best_ssd_q;
  assign best_idx  = best_idx_q;

endmodule

// File: tb/tb_ssd_best_match.sv
// Directed + randomized searches on a 4-candidate ssd_best_match, checked against a sum/min model.
module tb_ssd_best_match;

  localparam int BEATS = 16;
  localparam int CANDS = 4;
  localparam int IDX_W = 4;
  localparam int ACC_W = 22;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic             sqr_valid = 1'b0;
  logic [15:0]      z0 = '0, z1 = '0, z2 = '0, z3 = '0;
  logic             busy, ssd_valid, done;
  logic [ACC_W-1:0] ssd_out, best_ssd;
  logic [IDX_W-1:0] cand_idx, best_idx;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cz[CANDS][BEATS][4];
  int unsigned seen_ssd[$];
  int unsigned seen_idx[$];

  ssd_best_match #(.BEATS(BEATS), .CANDS(CANDS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .sqr_valid (sqr_valid),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .z3        (z3),
    .busy      (busy),
    .ssd_valid (ssd_valid),
    .ssd_out   (ssd_out),
    .cand_idx  (cand_idx),
    .done      (done),
    .best_ssd  (best_ssd),
    .best_idx  (best_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ssd_valid === 1'b1) begin
      seen_ssd.push_back(int'(ssd_out));
      seen_idx.push_back(int'(cand_idx));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int unsigned a, input int unsigned b,
                       input int unsigned c, input int unsigned d);
    sqr_valid = v;
    z0 = 16'(a);
    z1 = 16'(b);
    z2 = 16'(c);
    z3 = 16'(d);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input int unsigned v0, input int unsigned v1,
                            input int unsigned v2, input int unsigned v3);
    for (int c = 0; c < CANDS; c++)
      for (int b = 0; b < BEATS; b++) begin
        cz[c][b][0] = v0; cz[c][b][1] = v1; cz[c][b][2] = v2; cz[c][b][3] = v3;
      end
  endtask

  task automatic fill_targets(input int unsigned t0, input int unsigned t1,
                              input int unsigned t2, input int unsigned t3);
    fill_const(0, 0, 0, 0);
    cz[0][0][0] = t0;
    cz[1][3][1] = t1;
    cz[2][BEATS-1][2] = t2;
    cz[3][7][3] = t3;
  endtask

  task automatic fill_random();
    for (int c = 0; c < CANDS; c++)
      for (int b = 0; b < BEATS; b++)
        for (int l = 0; l < 4; l++)
          cz[c][b][l] = $urandom_range(65025, 0);
  endtask

  // Starts a search (optionally aborting one after abort_beats), feeds cz[], checks the results.
  task automatic run_search(input string name, input int gap_pct, input int abort_beats);
    int unsigned exp_ssd[CANDS];
    int unsigned best_s;
    int          best_i;
    for (int c = 0; c < CANDS; c++) begin
      exp_ssd[c] = 0;
      for (int b = 0; b < BEATS; b++)
        for (int l = 0; l < 4; l++)
          exp_ssd[c] += cz[c][b][l];
    end
    best_s = exp_ssd[0];
    best_i = 0;
    for (int c = 1; c < CANDS; c++)
      if (exp_ssd[c] < best_s) begin
        best_s = exp_ssd[c];
        best_i = c;
      end

    seen_ssd.delete();
    seen_idx.delete();
    start = 1'b1;
    drive(1, 9, 9, 9, 9);
    step();
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1);
    if (abort_beats > 0) begin
      for (int i = 0; i < abort_beats; i++) begin
        drive(1, 7, 7, 7, 7);
        step();
      end
      start = 1'b1;
      drive(1, 9, 9, 9, 9);
      step();
      start = 1'b0;
      chk({name, "_busy_after_restart"}, busy, 1);
    end

    for (int c = 0; c < CANDS; c++)
      for (int b = 0; b < BEATS; b++) begin
        while ($urandom_range(99, 0) < gap_pct) begin
          drive(0, $urandom_range(65025, 0), $urandom_range(65025, 0),
                $urandom_range(65025, 0), $urandom_range(65025, 0));
          step();
        end
        drive(1, cz[c][b][0], cz[c][b][1], cz[c][b][2], cz[c][b][3]);
        step();
      end

    // Trailing valid beats after the final one must not be counted.
    drive(1, 11, 11, 11, 11);
    step();
    chk({name, "_last_ssd_valid"}, ssd_valid, 1);
    chk({name, "_last_cand_idx"}, cand_idx, CANDS - 1);
    chk({name, "_last_ssd_out"}, ssd_out, exp_ssd[CANDS-1]);
    chk({name, "_done_early"}, done, 0);
    step();
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_ssd_valid_at_done"}, ssd_valid, 0);
    chk({name, "_best_ssd"}, best_ssd, best_s);
    chk({name, "_best_idx"}, best_idx, best_i);
    drive(0, 0, 0, 0, 0);

    chk({name, "_n_ssd_valid"}, seen_ssd.size(), CANDS);
    for (int i = 0; i < seen_ssd.size() && i < CANDS; i++) begin
      chk($sformatf("%s_ssd%0d", name, i), seen_ssd[i], exp_ssd[i]);
      chk($sformatf("%s_idx%0d", name, i), seen_idx[i], i);
    end
  endtask

  initial begin
    nrst = 1'b0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_ssd_valid", ssd_valid, 0);
    chk("rst_ssd_out", ssd_out, 0);
    chk("rst_cand_idx", cand_idx, 0);
    chk("rst_done", done, 0);
    chk("rst_best_ssd", best_ssd, 0);
    chk("rst_best_idx", best_idx, 0);
    nrst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(1, 5, 5, 5, 5);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ssd_out", ssd_out, 0);
    chk("idle_n_ssd_valid", seen_ssd.size(), 0);

    fill_const(1, 1, 1, 1);
    run_search("ones", 0, 0);
    fill_const(65025, 65025, 65025, 65025);
    run_search("sat", 0, 0);
    fill_targets(100, 50, 50, 70);
    run_search("tie", 0, 0);
    fill_const(3, 0, 0, 0);
    run_search("gap30", 30, 0);
    fill_const(2, 2, 2, 2);
    run_search("restart", 0, 10);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_search($sformatf("rand%0d", r), 25, 0);
    end

    // Reset in the middle of a search after one candidate has completed.
    start = 1'b1;
    drive(0, 0, 0, 0, 0);
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 1, 1, 1);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("mid_busy", busy, 1);
    chk("mid_ssd_out", ssd_out, 64);
    chk("mid_best_ssd", best_ssd, 64);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_ssd_valid", ssd_valid, 0);
    chk("mrst_ssd_out", ssd_out, 0);
    chk("mrst_cand_idx", cand_idx, 0);
    chk("mrst_done", done, 0);
    chk("mrst_best_ssd", best_ssd, 0);
    chk("mrst_best_idx", best_idx, 0);

    seen_ssd.delete();
    seen_idx.delete();
    for (int i = 0; i < 24; i++) begin
      drive(1, 4, 4, 4, 4);
      step();
    end
    drive(0, 0, 0, 0, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ssd_out", ssd_out, 0);
    chk("post_rst_n_ssd_valid", seen_ssd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
